// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle of ID-stage hazard inputs and pipeline control /
//                performance-counter outputs for the hazard controller.
//                master = pipeline side (drives ID-stage info, receives
//                controls), slave = hazard controller.
//  Ports       : start_i, id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i,
//                id_memread_i, id_rd_i, id_redirect_i, dmem_busy_i  (to ctrl)
//                pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
//                stall_cnt_o, flush_cnt_o, freeze_cnt_o            (from ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              start_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_uses_rt_i;
  logic              id_memread_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_redirect_i;
  logic              dmem_busy_i;

  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic [CNT_W-1:0]  freeze_cnt_o;

  modport master (
    output start_i, id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i,
           id_memread_i, id_rd_i, id_redirect_i, dmem_busy_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );

  modport slave (
    input  start_i, id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i,
           id_memread_i, id_rd_i, id_redirect_i, dmem_busy_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Parametrised load-use hazard controller for the 5-stage
//                core. A LOAD_LAT-deep scoreboard tracks in-flight load
//                destinations (entry 0 = instruction in EX). Generates
//                PC / IF/ID / ID/EX stall, bubble and flush controls, honours
//                data-memory busy and the start gate, and keeps saturating
//                performance counters.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous active-low reset
//                bus    - hazard_ctrl_if.slave (ID info in, controls and
//                         counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  logic                             frz;
  logic                             haz;
  logic                             push;
  logic [LOAD_LAT-1:0]              hit;

  logic [LOAD_LAT-1:0]              sb_v_q,  sb_v_d,  v_shift;
  logic [LOAD_LAT-1:0][REG_AW-1:0]  sb_rd_q, sb_rd_d, rd_shift;

  logic [CNT_W-1:0]                 stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]                 flush_cnt_q,  flush_cnt_d;
  logic [CNT_W-1:0]                 freeze_cnt_q, freeze_cnt_d;

  logic                             pc_write;
  logic                             ifid_write;
  logic                             ifid_flush;
  logic                             idex_bubble;

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign frz = !bus.start_i | bus.dmem_busy_i;

  // $0 is hard-wired; a load to it can never create a dependence.
  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_hit
    assign hit[k] = sb_v_q[k] && (sb_rd_q[k] != '0) &&
                    ((sb_rd_q[k] == bus.id_rs_i) ||
                     (bus.id_uses_rt_i && (sb_rd_q[k] == bus.id_rt_i)));
  end

  assign haz  = bus.id_valid_i & !frz & (|hit);

  // A stalled instruction is not pushed: the slot entering EX is a bubble.
  assign push = bus.id_valid_i & !haz & bus.id_memread_i & (bus.id_rd_i != '0);

  // --------------------------------------------------------------------------
  // Scoreboard shift: entry 0 takes the instruction leaving ID, every other
  // entry moves one stage further down the pipe.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_shift
    if (k == 0) begin : g_head
      assign v_shift[k]  = push;
      assign rd_shift[k] = bus.id_rd_i;
    end else begin : g_tail
      assign v_shift[k]  = sb_v_q[k-1];
      assign rd_shift[k] = sb_rd_q[k-1];
    end
  end

  // A freeze holds every stage, so the scoreboard holds too; the stall is
  // extended rather than consumed.
  always_comb begin
    sb_v_d  = sb_v_q;
    sb_rd_d = sb_rd_q;
    if (!frz) begin
      sb_v_d  = v_shift;
      sb_rd_d = rd_shift;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline controls: reset > freeze > hazard > redirect
  // --------------------------------------------------------------------------
  always_comb begin
    // Reset values are driven straight from the asynchronous reset so the
    // pipeline is safe before the first clock.
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    if (rst_i) begin
      if (frz) begin
        // Everything holds, including ID/EX (no bubble injected).
        idex_bubble = 1'b0;
      end else if (haz) begin
        // Redirect is ignored here; the branch re-resolves after the stall.
        idex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = bus.id_valid_i & bus.id_redirect_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (haz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + C_CNT_ONE;
    end
    if (frz && (freeze_cnt_q != '1)) begin
      freeze_cnt_d = freeze_cnt_q + C_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb_v_q       <= '0;
      sb_rd_q      <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      sb_v_q       <= sb_v_d;
      sb_rd_q      <= sb_rd_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_bubble_o = idex_bubble;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;
  assign bus.freeze_cnt_o  = freeze_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Three instances share
//                one stimulus: u_a (LOAD_LAT=1), u_b (LOAD_LAT=3),
//                u_c (LOAD_LAT=1, CNT_W=4). Directed vector table on u_b,
//                hand sequences for latency-1, saturation and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  typedef struct packed {
    logic       start;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] rd;
    logic       redirect;
    logic       busy;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [3:0] exp;   // {pc_write, ifid_write, ifid_flush, idex_bubble}
  } vec_t;

  localparam logic [3:0] NORM = 4'b1100;
  localparam logic [3:0] FLSH = 4'b1110;
  localparam logic [3:0] STAL = 4'b0001;
  localparam logic [3:0] FRZ  = 4'b0000;
  localparam logic [3:0] RSTV = 4'b0001;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  in_t  cur;

  int n_pass  = 0;
  int n_total = 0;

  vec_t tv[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_a ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_b ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  bus_c ();

  assign {bus_a.start_i, bus_a.id_valid_i, bus_a.id_rs_i, bus_a.id_rt_i, bus_a.id_uses_rt_i,
          bus_a.id_memread_i, bus_a.id_rd_i, bus_a.id_redirect_i, bus_a.dmem_busy_i} = cur;
  assign {bus_b.start_i, bus_b.id_valid_i, bus_b.id_rs_i, bus_b.id_rt_i, bus_b.id_uses_rt_i,
          bus_b.id_memread_i, bus_b.id_rd_i, bus_b.id_redirect_i, bus_b.dmem_busy_i} = cur;
  assign {bus_c.start_i, bus_c.id_valid_i, bus_c.id_rs_i, bus_c.id_rt_i, bus_c.id_uses_rt_i,
          bus_c.id_memread_i, bus_c.id_rd_i, bus_c.id_redirect_i, bus_c.dmem_busy_i} = cur;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_a (.clk_i(clk), .rst_i(rst_n), .bus(bus_a));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_b (.clk_i(clk), .rst_i(rst_n), .bus(bus_b));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4))  u_c (.clk_i(clk), .rst_i(rst_n), .bus(bus_c));

  logic [3:0] ctl_a, ctl_b, ctl_c;
  assign ctl_a = {bus_a.pc_write_o, bus_a.ifid_write_o, bus_a.ifid_flush_o, bus_a.idex_bubble_o};
  assign ctl_b = {bus_b.pc_write_o, bus_b.ifid_write_o, bus_b.ifid_flush_o, bus_b.idex_bubble_o};
  assign ctl_c = {bus_c.pc_write_o, bus_c.ifid_write_o, bus_c.ifid_flush_o, bus_c.idex_bubble_o};

  // ---------------------------------------------------------------- helpers
  function automatic in_t mk(int v, int rs, int rt, int urt, int mr, int rd,
                             int rdir, int st, int bz);
    in_t r;
    r.valid    = v[0];
    r.rs       = rs[4:0];
    r.rt       = rt[4:0];
    r.uses_rt  = urt[0];
    r.memread  = mr[0];
    r.rd       = rd[4:0];
    r.redirect = rdir[0];
    r.start    = st[0];
    r.busy     = bz[0];
    return r;
  endfunction

  function automatic in_t op(int rs, int rt, int rd);   // R-type, reads rs and rt
    return mk(1, rs, rt, 1, 0, rd, 0, 1, 0);
  endfunction

  function automatic in_t ld(int rs, int rd);           // load rd <- [rs]
    return mk(1, rs, 0, 0, 1, rd, 0, 1, 0);
  endfunction

  function automatic in_t br(int rs, int rt);           // taken branch
    return mk(1, rs, rt, 1, 0, 0, 1, 1, 0);
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic add(input in_t x, input logic [3:0] e);
    tv.push_back({x, e});
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Drive on the falling edge, settle, return for sampling.
  task automatic step(input in_t v);
    @(negedge clk);
    cur = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cur = idle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    cur = idle();

    // Vector table for u_b (LOAD_LAT=3)
    add(op(1, 2, 3), NORM);
    add(ld(1, 5), NORM);                                  // lw $5
    add(op(5, 6, 8), STAL); add(op(5, 6, 8), STAL);       // immediate user: 3 stalls
    add(op(5, 6, 8), STAL); add(op(5, 6, 8), NORM);
    add(ld(1, 5), NORM);                                  // lw $5
    add(op(1, 2, 9), NORM);                               // independent
    add(op(5, 6, 8), STAL); add(op(5, 6, 8), STAL);       // user 2 after: 2 stalls
    add(op(5, 6, 8), NORM);
    add(ld(1, 0), NORM);                                  // lw $0 not tracked
    add(op(0, 0, 10), NORM);
    add(ld(1, 7), NORM);                                  // lw $7
    add(mk(1, 1, 7, 0, 0, 10, 0, 1, 0), NORM);            // rt=$7 not read
    add(op(2, 7, 11), STAL); add(op(2, 7, 11), STAL);     // rt=$7 read
    add(op(2, 7, 11), NORM);
    add(br(1, 2), FLSH);                                  // taken beq, no hazard
    add(ld(1, 4), NORM);                                  // lw $4
    add(mk(0, 4, 0, 0, 0, 0, 1, 1, 0), NORM);             // invalid slot, redirect ignored
    add(br(4, 1), STAL); add(br(4, 1), STAL);             // beq waits, then flushes
    add(br(4, 1), FLSH);
    add(ld(1, 6), NORM);                                  // lw $6
    add(op(6, 1, 12), STAL);
    for (int i = 0; i < 4; i++) add(mk(1, 6, 1, 1, 0, 12, 0, 1, 1), FRZ);
    add(op(6, 1, 12), STAL); add(op(6, 1, 12), STAL);     // remaining stall
    add(op(6, 1, 12), NORM);
    add(mk(1, 1, 2, 1, 0, 0, 1, 0, 0), FRZ);              // start low beats redirect
    add(mk(1, 1, 0, 0, 1, 5, 0, 1, 1), FRZ);              // frozen load not pushed
    add(op(5, 1, 13), NORM);

    // Reset state (asynchronous)
    #1 rst_n = 1'b0;
    #1;
    check("reset ctl a", ctl_a, RSTV);
    check("reset ctl b", ctl_b, RSTV);
    check("reset stall_cnt b", bus_b.stall_cnt_o, 0);
    check("reset freeze_cnt b", bus_b.freeze_cnt_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].in);
      check($sformatf("vec%0d ctl b", i), ctl_b, tv[i].exp);
    end
    step(idle());
    check("table stall_cnt b", bus_b.stall_cnt_o, 12);
    check("table flush_cnt b", bus_b.flush_cnt_o, 2);
    check("table freeze_cnt b", bus_b.freeze_cnt_o, 6);

    // LOAD_LAT=1: single bubble
    do_reset();
    step(ld(1, 2));     check("lat1 load ctl a", ctl_a, NORM);
    step(op(2, 4, 3));  check("lat1 stall ctl a", ctl_a, STAL);
    step(op(2, 4, 3));  check("lat1 issue ctl a", ctl_a, NORM);
    step(idle());
    check("lat1 stall_cnt a", bus_a.stall_cnt_o, 1);
    check("lat1 flush_cnt a", bus_a.flush_cnt_o, 0);

    // Saturation: 20 hazard cycles on a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(ld(1, 3));
      step(op(3, 1, 4));
      step(op(3, 1, 4));
    end
    step(idle());
    check("sat stall_cnt c", bus_c.stall_cnt_o, 15);
    check("nosat stall_cnt a", bus_a.stall_cnt_o, 20);

    // Reset asserted mid-stall
    step(ld(1, 3));
    step(op(3, 1, 4));
    check("pre-reset stall ctl c", ctl_c, STAL);
    cur.busy = 1'b1;
    #1 check("pre-reset freeze ctl c", ctl_c, FRZ);
    rst_n = 1'b0;
    #1;
    check("async reset ctl c", ctl_c, RSTV);
    check("async reset stall_cnt c", bus_c.stall_cnt_o, 0);
    check("async reset freeze_cnt c", bus_c.freeze_cnt_o, 0);
    check("async reset stall_cnt a", bus_a.stall_cnt_o, 0);
    cur.busy = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("post-reset no stall ctl c", ctl_c, NORM);
    step(idle());
    check("post-reset stall_cnt c", bus_c.stall_cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
